// File: rtl/axis_packet_arbiter.sv
// Packet-level round-robin arbiter merging NUM_SOURCES AXI-Stream inputs onto one output.
// The grant is locked from a packet's first beat until its last beat is accepted.
module axis_packet_arbiter #(
   parameter int NUM_SOURCES     = 4,
   parameter int DATA_WIDTH      = 32,
   parameter int DATA_BYTE_WIDTH = DATA_WIDTH/8,
   parameter int GRANT_WIDTH     = $clog2(NUM_SOURCES)
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [NUM_SOURCES-1:0]                 valid_in,
   input  logic [NUM_SOURCES*DATA_WIDTH-1:0]      data_in,
   input  logic [NUM_SOURCES*DATA_BYTE_WIDTH-1:0] keep_in,
   input  logic [NUM_SOURCES-1:0]                 last_in,
   output logic [NUM_SOURCES-1:0]                 ready_out,
   output logic                                   valid_out,
   output logic [DATA_WIDTH-1:0]                  data_out,
   output logic [DATA_BYTE_WIDTH-1:0]             keep_out,
   output logic                                   last_out,
   input  logic                                   ready_in,
   output logic [GRANT_WIDTH-1:0]                 grant_out,
   output logic                                   busy_out
);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t                 state, state_nxt;
   logic [GRANT_WIDTH-1:0] grant, grant_nxt, prio_ptr, prio_nxt;
   logic [GRANT_WIDTH-1:0] grant_inc, scan_start, pick_idx;
   logic [NUM_SOURCES-1:0] req;
   logic                   pick_vld, locked, accept;

   logic [NUM_SOURCES-1:0][DATA_WIDTH-1:0]      data_arr;
   logic [NUM_SOURCES-1:0][DATA_BYTE_WIDTH-1:0] keep_arr;

   assign data_arr  = data_in;
   assign keep_arr  = keep_in;
   assign locked    = (state == LOCKED);
   assign grant_inc = (grant == GRANT_WIDTH'(NUM_SOURCES-1)) ? '0 : grant + GRANT_WIDTH'(1);
   assign accept    = locked & valid_in[grant] & ready_in;
   assign grant_out = grant;

   // While locked, the current owner is masked and the scan starts just past it,
   // so the next packet can follow the last beat with no bubble.
   always_comb begin
      req        = valid_in;
      scan_start = prio_ptr;
      if (locked) begin
         req[grant] = 1'b0;
         scan_start = grant_inc;
      end
   end

   // Descending loop: the lowest offset from scan_start is assigned last and wins.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      for (int k = NUM_SOURCES-1; k >= 0; k--) begin
         if (req[(int'(scan_start) + k) % NUM_SOURCES]) begin
            pick_vld = 1'b1;
            pick_idx = GRANT_WIDTH'((int'(scan_start) + k) % NUM_SOURCES);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      prio_nxt  = prio_ptr;
      valid_out = 1'b0;
      data_out  = '0;
      keep_out  = '0;
      last_out  = 1'b0;
      ready_out = '0;
      busy_out  = 1'b0;
      case (state)
         IDLE: begin
            if (pick_vld) begin
               state_nxt = LOCKED;
               grant_nxt = pick_idx;
            end
         end
         LOCKED: begin
            valid_out        = valid_in[grant];
            data_out         = data_arr[grant];
            keep_out         = keep_arr[grant];
            last_out         = last_in[grant];
            ready_out[grant] = ready_in;
            busy_out         = 1'b1;
            if (accept && last_in[grant]) begin
               prio_nxt = grant_inc;
               if (pick_vld) grant_nxt = pick_idx;
               else          state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         grant    <= '0;
         prio_ptr <= '0;
      end else begin
         state    <= state_nxt;
         grant    <= grant_nxt;
         prio_ptr <= prio_nxt;
      end
   end

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Directed bench for axis_packet_arbiter: per-source packet generators plus
// cycle-by-cycle checks of the merged stream against hand-derived values.
module tb_axis_packet_arbiter;

   localparam int NS = 4;
   localparam int DW = 32;
   localparam int KW = DW/8;
   localparam int GW = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [NS-1:0]     valid_in, last_in, ready_out;
   logic [NS*DW-1:0]  data_in;
   logic [NS*KW-1:0]  keep_in;
   logic              valid_out, last_out, ready_in, busy_out;
   logic [DW-1:0]     data_out;
   logic [KW-1:0]     keep_out;
   logic [GW-1:0]     grant_out;

   int checks   = 0;
   int failures = 0;

   // Source generator state: packets of plen beats, sends while pkt < npkts.
   int beat [NS];
   int pkt  [NS];
   int plen [NS];
   int npkts[NS];
   logic src_clr;

   axis_packet_arbiter #(.NUM_SOURCES(NS), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst),
      .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
      .ready_out(ready_out),
      .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
      .ready_in(ready_in), .grant_out(grant_out), .busy_out(busy_out)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] expd(input int s, input int p, input int b);
      return {8'(s), 8'(p), 8'(b), 8'hC3};
   endfunction

   function automatic logic [KW-1:0] expk(input int b);
      return 4'hF ^ 4'(b);
   endfunction

   always_comb begin
      valid_in = '0;
      last_in  = '0;
      data_in  = '0;
      keep_in  = '0;
      for (int i = 0; i < NS; i++) begin
         valid_in[i]          = (pkt[i] < npkts[i]);
         last_in[i]           = (beat[i] == plen[i]-1);
         data_in[i*DW +: DW]  = expd(i, pkt[i], beat[i]);
         keep_in[i*KW +: KW]  = expk(beat[i]);
      end
   end

   always @(posedge clk) begin
      for (int i = 0; i < NS; i++) begin
         if (src_clr) begin
            beat[i] <= 0;
            pkt[i]  <= 0;
         end else if (valid_in[i] && ready_out[i]) begin
            if (last_in[i]) begin
               beat[i] <= 0;
               pkt[i]  <= pkt[i] + 1;
            end else begin
               beat[i] <= beat[i] + 1;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic idle_chk(input string tag);
      chk({tag, "_busy"},  64'(busy_out), 64'd0);
      chk({tag, "_valid"}, 64'(valid_out), 64'd0);
      chk({tag, "_ready"}, 64'(ready_out), 64'd0);
   endtask

   task automatic beat_chk(input string tag, input int s, input int p, input int b, input bit l);
      chk({tag, "_busy"},  64'(busy_out), 64'd1);
      chk({tag, "_grant"}, 64'(grant_out), 64'(s));
      chk({tag, "_valid"}, 64'(valid_out), 64'd1);
      chk({tag, "_data"},  64'(data_out), 64'(expd(s, p, b)));
      chk({tag, "_keep"},  64'(keep_out), 64'(expk(b)));
      chk({tag, "_last"},  64'(last_out), 64'(l));
   endtask

   task automatic clear_src();
      for (int i = 0; i < NS; i++) begin
         npkts[i] = 0;
         plen[i]  = 1;
      end
      src_clr = 1'b1;
      tick();
      src_clr = 1'b0;
   endtask

   initial begin
      int order [6];
      order = '{0, 1, 2, 3, 0, 1};
      rst = 1'b1;
      ready_in = 1'b1;
      for (int i = 0; i < NS; i++) begin
         npkts[i] = 0;
         plen[i]  = 1;
      end
      src_clr = 1'b1;
      repeat (3) tick();
      idle_chk("rst");
      chk("rst_grant", 64'(grant_out), 64'd0);
      chk("rst_data",  64'(data_out), 64'd0);
      chk("rst_prio",  64'(dut.prio_ptr), 64'd0);
      rst = 1'b0;
      src_clr = 1'b0;

      // All four sources, 2-beat packets: order 0,1,2,3,0,1 back to back.
      for (int i = 0; i < NS; i++) plen[i] = 2;
      npkts[0] = 2; npkts[1] = 2; npkts[2] = 1; npkts[3] = 1;
      #1;
      idle_chk("rr_arb");
      for (int k = 0; k < 12; k++) begin
         tick();
         beat_chk($sformatf("rr_b%0d", k), order[k/2], k/8, k%2, (k%2) == 1);
      end
      tick();
      idle_chk("rr_end");
      chk("rr_prio", 64'(dut.prio_ptr), 64'd2);

      // Single source 2, 3-beat packet.
      clear_src();
      plen[2] = 3; npkts[2] = 1;
      #1;
      idle_chk("s2_arb");
      tick(); beat_chk("s2_d0", 2, 0, 0, 1'b0);
      chk("s2_rdy", 64'(ready_out), 64'b0100);
      tick(); beat_chk("s2_d1", 2, 0, 1, 1'b0);
      tick(); beat_chk("s2_d2", 2, 0, 2, 1'b1);
      tick(); idle_chk("s2_end");
      chk("s2_prio", 64'(dut.prio_ptr), 64'd3);

      // prio_ptr=3, sources 1 and 3 single-beat: 3 first, then 1 with no bubble.
      clear_src();
      npkts[1] = 1; npkts[3] = 1;
      #1;
      idle_chk("wrap_arb");
      tick(); beat_chk("wrap_s3", 3, 0, 0, 1'b1);
      tick(); beat_chk("wrap_s1", 1, 0, 0, 1'b1);
      chk("wrap_prio0", 64'(dut.prio_ptr), 64'd0);
      tick(); idle_chk("wrap_end");
      chk("wrap_prio2", 64'(dut.prio_ptr), 64'd2);

      // Source 0 stalled mid-packet for 5 cycles while source 1 requests.
      clear_src();
      plen[0] = 3; npkts[0] = 1;
      #1;
      tick(); beat_chk("bp_d0", 0, 0, 0, 1'b0);
      tick();
      ready_in = 1'b0;
      plen[1] = 1; npkts[1] = 1;
      #1;
      for (int c = 0; c < 5; c++) begin
         if (c != 0) tick();
         beat_chk($sformatf("bp_stall%0d", c), 0, 0, 1, 1'b0);
         chk($sformatf("bp_rdy%0d", c), 64'(ready_out), 64'b0000);
      end
      ready_in = 1'b1;
      #1;
      chk("bp_rdy_rel", 64'(ready_out), 64'b0001);
      tick(); beat_chk("bp_d2", 0, 0, 2, 1'b1);
      tick(); beat_chk("bp_s1", 1, 0, 0, 1'b1);
      tick(); idle_chk("bp_end");

      // Reset on beat 2 of a 4-beat packet from source 1; upstream restarts it.
      clear_src();
      plen[1] = 4; npkts[1] = 1;
      #1;
      tick(); beat_chk("mr_d0", 1, 0, 0, 1'b0);
      tick(); beat_chk("mr_d1", 1, 0, 1, 1'b0);
      rst = 1'b1;
      src_clr = 1'b1;
      tick();
      rst = 1'b0;
      src_clr = 1'b0;
      #1;
      idle_chk("mr_post");
      chk("mr_prio", 64'(dut.prio_ptr), 64'd0);
      for (int b = 0; b < 4; b++) begin
         tick();
         beat_chk($sformatf("mr_r%0d", b), 1, 0, b, b == 3);
      end
      tick(); idle_chk("mr_end");

      // Source 0 alone, back-to-back single-beat packets: one IDLE cycle each.
      clear_src();
      npkts[0] = 3;
      #1;
      idle_chk("one_arb");
      for (int p = 0; p < 3; p++) begin
         tick(); beat_chk($sformatf("one_p%0d", p), 0, p, 0, 1'b1);
         tick(); idle_chk($sformatf("one_gap%0d", p));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
